// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one of int/mem/mult/div per cycle and registers its result onto the CDB.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority div > mult > mem > int.
module cdb_arbiter #(
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  int_req,
    input  logic                  mem_req,
    input  logic                  mult_req,
    input  logic                  div_req,
    input  logic [TAG_WIDTH-1:0]  int_tag,
    input  logic [TAG_WIDTH-1:0]  mem_tag,
    input  logic [TAG_WIDTH-1:0]  mult_tag,
    input  logic [TAG_WIDTH-1:0]  div_tag,
    input  logic [DATA_WIDTH-1:0] int_data,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mult_data,
    input  logic [DATA_WIDTH-1:0] div_data,
    input  logic                  int_branch,
    input  logic                  int_branch_taken,
    output logic                  int_grant,
    output logic                  mem_grant,
    output logic                  mult_grant,
    output logic                  div_grant,
    output logic                  cdb_valid,
    output logic [TAG_WIDTH-1:0]  cdb_tag,
    output logic [DATA_WIDTH-1:0] cdb_data,
    output logic                  cdb_branch,
    output logic                  cdb_branch_taken
);

    logic [3:0]            req;
    logic [3:0]            grant;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [DATA_WIDTH-1:0] sel_data;

    assign req = {div_req, mult_req, mem_req, int_req};
    assign {div_grant, mult_grant, mem_grant, int_grant} = grant;

`ifdef CDB_ARB_RR_EN
    logic [1:0] ptr;
    logic [1:0] grant_idx;
    logic [1:0] idx;
    logic       found;

    // Search from ptr upward (mod 4); first requester found wins
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        idx       = ptr;
        found     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (found && !rst) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= grant_idx + 2'd1;
        end
    end
`else
    // Long-latency units drain first to free their single-entry output stage
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (req[3]) begin
                grant = 4'b1000;
            end else if (req[2]) begin
                grant = 4'b0100;
            end else if (req[1]) begin
                grant = 4'b0010;
            end else if (req[0]) begin
                grant = 4'b0001;
            end
        end
    end
`endif

    always_comb begin
        sel_tag  = int_tag;
        sel_data = int_data;
        if (grant[1]) begin
            sel_tag  = mem_tag;
            sel_data = mem_data;
        end else if (grant[2]) begin
            sel_tag  = mult_tag;
            sel_data = mult_data;
        end else if (grant[3]) begin
            sel_tag  = div_tag;
            sel_data = div_data;
        end
    end

    // Tag/data hold their last value when idle; branch flags only accompany a valid int broadcast
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid        <= 1'b0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end else if (|grant) begin
            cdb_valid        <= 1'b1;
            cdb_tag          <= sel_tag;
            cdb_data         <= sel_data;
            cdb_branch       <= grant[0] & int_branch;
            cdb_branch_taken <= grant[0] & int_branch_taken;
        end else begin
            cdb_valid        <= 1'b0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expectations follow CDB_ARB_RR_EN when defined.
module tb_cdb_arbiter;

    localparam logic [5:0]  T_INT  = 6'h01;
    localparam logic [5:0]  T_BR   = 6'h03;
    localparam logic [5:0]  T_MEM  = 6'h02;
    localparam logic [5:0]  T_MULT = 6'h0A;
    localparam logic [5:0]  T_DIV  = 6'h04;
    localparam logic [31:0] D_INT  = 32'h1111_0001;
    localparam logic [31:0] D_MEM  = 32'h2222_0002;
    localparam logic [31:0] D_MULT = 32'hDEAD_BEEF;
    localparam logic [31:0] D_DIV  = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_req, mem_req, mult_req, div_req;
    logic [5:0]  int_tag, mem_tag, mult_tag, div_tag;
    logic [31:0] int_data, mem_data, mult_data, div_data;
    logic        int_branch, int_branch_taken;
    logic        int_grant, mem_grant, mult_grant, div_grant;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_branch, cdb_branch_taken;
    logic [3:0]  g;
    int          total = 0;
    int          bad   = 0;

    assign g = {div_grant, mult_grant, mem_grant, int_grant};

    always #5 clk = ~clk;

    cdb_arbiter #(.TAG_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .int_req(int_req), .mem_req(mem_req), .mult_req(mult_req), .div_req(div_req),
        .int_tag(int_tag), .mem_tag(mem_tag), .mult_tag(mult_tag), .div_tag(div_tag),
        .int_data(int_data), .mem_data(mem_data), .mult_data(mult_data), .div_data(div_data),
        .int_branch(int_branch), .int_branch_taken(int_branch_taken),
        .int_grant(int_grant), .mem_grant(mem_grant), .mult_grant(mult_grant), .div_grant(div_grant),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
    );

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Drive requests after the falling edge, check grants, then check the CDB just after the rising edge
    task automatic applyStimulus(input string name, input logic [3:0] r, input logic [3:0] eg,
                                 input logic ev, input logic [5:0] et, input logic [31:0] ed);
        @(negedge clk);
        {div_req, mult_req, mem_req, int_req} = r;
        #1;
        checkOutput({name, "/grant"}, {28'd0, g}, {28'd0, eg});
        @(posedge clk);
        #1;
        checkOutput({name, "/valid"}, {31'd0, cdb_valid}, {31'd0, ev});
        if (ev) begin
            checkOutput({name, "/tag"}, {26'd0, cdb_tag}, {26'd0, et});
            checkOutput({name, "/data"}, cdb_data, ed);
        end
    endtask

    initial begin
        logic [3:0] rot_g [4];
        logic [5:0] rot_t [4];
        rot_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rot_t = '{T_INT, T_MEM, T_MULT, T_DIV};

        rst = 1'b1;
        {div_req, mult_req, mem_req, int_req} = 4'b0000;
        int_tag = T_INT;   int_data = D_INT;
        mem_tag = T_MEM;   mem_data = D_MEM;
        mult_tag = T_MULT; mult_data = D_MULT;
        div_tag = T_DIV;   div_data = D_DIV;
        int_branch = 1'b0; int_branch_taken = 1'b0;

        $display("[TB] reset with all requests high");
        applyStimulus("rst1", 4'b1111, 4'b0000, 1'b0, 6'h00, 32'h0);
        checkOutput("rst1/tag", {26'd0, cdb_tag}, 32'h0);
        checkOutput("rst1/data", cdb_data, 32'h0);
        applyStimulus("rst2", 4'b1111, 4'b0000, 1'b0, 6'h00, 32'h0);
        checkOutput("rst2/branch", {31'd0, cdb_branch}, 32'h0);
        rst = 1'b0;
`ifdef CDB_ARB_RR_EN
        applyStimulus("first", 4'b1111, 4'b0001, 1'b1, T_INT, D_INT);
`else
        applyStimulus("first", 4'b1111, 4'b1000, 1'b1, T_DIV, D_DIV);
`endif
        applyStimulus("idle1", 4'b0000, 4'b0000, 1'b0, 6'h00, 32'h0);
`ifdef CDB_ARB_RR_EN
        checkOutput("idle1/holdtag", {26'd0, cdb_tag}, {26'd0, T_INT});
`else
        checkOutput("idle1/holdtag", {26'd0, cdb_tag}, {26'd0, T_DIV});
`endif

        $display("[TB] single mult request");
        applyStimulus("mult", 4'b0100, 4'b0100, 1'b1, T_MULT, D_MULT);
        applyStimulus("mult_after", 4'b0000, 4'b0000, 1'b0, 6'h00, 32'h0);

        $display("[TB] branch broadcast");
        int_tag = T_BR; int_branch = 1'b1; int_branch_taken = 1'b1;
        applyStimulus("br", 4'b0001, 4'b0001, 1'b1, T_BR, D_INT);
        checkOutput("br/branch", {31'd0, cdb_branch}, 32'h1);
        checkOutput("br/taken", {31'd0, cdb_branch_taken}, 32'h1);
        applyStimulus("br_mem", 4'b0010, 4'b0010, 1'b1, T_MEM, D_MEM);
        checkOutput("br_mem/branch", {31'd0, cdb_branch}, 32'h0);
        checkOutput("br_mem/taken", {31'd0, cdb_branch_taken}, 32'h0);
        int_tag = T_INT; int_branch = 1'b0; int_branch_taken = 1'b0;
        applyStimulus("int_only", 4'b0001, 4'b0001, 1'b1, T_INT, D_INT);

        $display("[TB] hold and no-loss with mem and div together");
`ifdef CDB_ARB_RR_EN
        applyStimulus("hold_win", 4'b1010, 4'b0010, 1'b1, T_MEM, D_MEM);
        applyStimulus("hold_lose", 4'b1000, 4'b1000, 1'b1, T_DIV, D_DIV);
`else
        applyStimulus("hold_win", 4'b1010, 4'b1000, 1'b1, T_DIV, D_DIV);
        applyStimulus("hold_lose", 4'b0010, 4'b0010, 1'b1, T_MEM, D_MEM);
`endif
        applyStimulus("hold_idle", 4'b0000, 4'b0000, 1'b0, 6'h00, 32'h0);

`ifdef CDB_ARB_RR_EN
        $display("[TB] round-robin rotation");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("rot%0d", i), 4'b1111, rot_g[i % 4], 1'b1, rot_t[i % 4],
                          (i % 4 == 0) ? D_INT : (i % 4 == 1) ? D_MEM : (i % 4 == 2) ? D_MULT : D_DIV);
        end
`else
        $display("[TB] fixed priority drain order");
        applyStimulus("fix_div", 4'b1101, 4'b1000, 1'b1, T_DIV, D_DIV);
        applyStimulus("fix_mult", 4'b0101, 4'b0100, 1'b1, T_MULT, D_MULT);
        applyStimulus("fix_int", 4'b0001, 4'b0001, 1'b1, T_INT, D_INT);
`endif
        applyStimulus("idle2", 4'b0000, 4'b0000, 1'b0, 6'h00, 32'h0);

        $display("[TB] reset mid-operation");
        applyStimulus("pre_rst", 4'b0100, 4'b0100, 1'b1, T_MULT, D_MULT);
        rst = 1'b1;
        applyStimulus("mid_rst", 4'b0001, 4'b0000, 1'b0, 6'h00, 32'h0);
        checkOutput("mid_rst/tag", {26'd0, cdb_tag}, 32'h0);
        checkOutput("mid_rst/data", cdb_data, 32'h0);
        rst = 1'b0;
        applyStimulus("post_rst", 4'b0001, 4'b0001, 1'b1, T_INT, D_INT);
        applyStimulus("end_idle", 4'b0000, 4'b0000, 1'b0, 6'h00, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
